// File: rtl/corescore_stream_uart.sv
// Buffered AXI-stream to 8N1 UART transmitter: byte FIFO, optional CR/LF
// insertion after tlast bytes, and a stretched activity LED.
module corescore_stream_uart #(
    parameter int CLK_FREQ_HZ = 16000000,
    parameter int BAUD        = 57600,
    parameter int FIFO_AW     = 4,
    parameter int EOL_MODE    = 0,
    parameter int LED_STRETCH = 1600000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_tdata,
    input  logic               i_tlast,
    input  logic               i_tvalid,
    output logic               o_tready,
    output logic               o_uart_tx,
    output logic               o_led,
    output logic [FIFO_AW:0]   o_fifo_level
);
    localparam int DIV   = CLK_FREQ_HZ / BAUD;
    localparam int DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_M1 = DIV_W'(DIV - 1);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int LED_W = $clog2(LED_STRETCH + 1);
    localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_STRETCH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [8:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic [8:0]         head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               load;
    logic [7:0]         load_byte;

    logic [1:0]         state;
    logic [DIV_W-1:0]   baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shifter;
    logic [1:0]         eol_pend;
    logic               tx;
    logic [LED_W-1:0]   led_cnt;

    assign full     = (level == (FIFO_AW + 1)'(DEPTH));
    assign empty    = (level == '0);
    assign o_tready = !full && !i_rst;
    assign push     = i_tvalid && o_tready;
    assign head     = mem[rd_ptr];

    // Pending EOL characters take priority; the FIFO is only popped once they are gone.
    assign load = (state == S_IDLE) && ((eol_pend != 2'd0) || !empty);
    assign pop  = load && (eol_pend == 2'd0);

    always_comb begin
        load_byte = head[7:0];
        if (eol_pend == 2'd2) begin
            load_byte = 8'h0D;
        end else if (eol_pend == 2'd1) begin
            load_byte = 8'h0A;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_tlast, i_tdata};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // eol_pend counts characters still owed: 2 = CR then LF, 1 = LF.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
            eol_pend <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        state    <= S_START;
                        tx       <= 1'b0;
                        baud_cnt <= DIV_M1;
                        shifter  <= load_byte;
                        if (eol_pend != 2'd0) begin
                            eol_pend <= eol_pend - 1'b1;
                        end else if (head[8] && EOL_MODE == 1) begin
                            eol_pend <= 2'd1;
                        end else if (head[8] && EOL_MODE == 2) begin
                            eol_pend <= 2'd2;
                        end
                    end
                end
                S_START: begin
                    if (baud_cnt == '0) begin
                        state    <= S_DATA;
                        tx       <= shifter[0];
                        baud_cnt <= DIV_M1;
                        bit_idx  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= DIV_M1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shifter[1];
                            shifter <= {1'b0, shifter[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            led_cnt <= '0;
        end else if (load) begin
            led_cnt <= LED_LOAD;
        end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - 1'b1;
        end
    end

    assign o_led        = (led_cnt != '0);
    assign o_uart_tx    = tx;
    assign o_fifo_level = level;

endmodule

// File: tb/tb_corescore_stream_uart.sv
// Directed bench for corescore_stream_uart: two instances (CR+LF and LF-only)
// share the stream inputs; a UART line decoder collects bytes and start cycles.
module tb_corescore_stream_uart;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_tdata = 8'h00;
    logic       i_tlast = 1'b0;
    logic       i_tvalid = 1'b0;

    logic       tready_a, tx_a, led_a;
    logic [2:0] level_a;
    logic       tready_b, tx_b, led_b;
    logic [2:0] level_b;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    logic [7:0] rxa[$];
    int         rta[$];
    logic [7:0] rxb[$];
    int         rtb[$];
    int         mpos[2] = '{-1, -1};
    int         mstart[2];
    logic [7:0] mbyte[2];
    logic       mline;

    corescore_stream_uart #(
        .CLK_FREQ_HZ(1000), .BAUD(250), .FIFO_AW(2), .EOL_MODE(2), .LED_STRETCH(10)
    ) dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_tdata(i_tdata), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .o_tready(tready_a), .o_uart_tx(tx_a),
        .o_led(led_a), .o_fifo_level(level_a)
    );

    corescore_stream_uart #(
        .CLK_FREQ_HZ(1000), .BAUD(250), .FIFO_AW(2), .EOL_MODE(1), .LED_STRETCH(10)
    ) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_tdata(i_tdata), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .o_tready(tready_b), .o_uart_tx(tx_b),
        .o_led(led_b), .o_fifo_level(level_b)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Decoder: start detected at bit position 0, each bit sampled mid-way (DIV=4).
    always @(negedge i_clk) begin
        for (int m = 0; m < 2; m++) begin
            mline = (m == 0) ? tx_a : tx_b;
            if (i_rst) begin
                mpos[m] = -1;
            end else if (mpos[m] < 0) begin
                if (mline == 1'b0) begin
                    mpos[m] = 0;
                    mstart[m] = cyc;
                end
            end else begin
                mpos[m]++;
                if (mpos[m] == 2 && mline !== 1'b0) begin
                    mpos[m] = -1;
                end else if (mpos[m] >= 6 && mpos[m] <= 34 && ((mpos[m] - 2) % 4) == 0) begin
                    mbyte[m] = {mline, mbyte[m][7:1]};
                end else if (mpos[m] == 38) begin
                    if (m == 0) begin
                        checkOutput("stop_bit_a", 32'(mline), 32'd1);
                        rxa.push_back(mbyte[m]);
                        rta.push_back(mstart[m]);
                    end else begin
                        checkOutput("stop_bit_b", 32'(mline), 32'd1);
                        rxb.push_back(mbyte[m]);
                        rtb.push_back(mstart[m]);
                    end
                    mpos[m] = -1;
                end
            end
        end
    end

    task automatic applyReset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
        i_tdata = 8'h00;
        @(negedge i_clk);
        checkOutput("rst_tx", 32'(tx_a), 32'd1);
        checkOutput("rst_tready", 32'(tready_a), 32'd0);
        checkOutput("rst_level", 32'(level_a), 32'd0);
        checkOutput("rst_led", 32'(led_a), 32'd0);
        i_rst = 1'b0;
        rxa.delete(); rta.delete(); rxb.delete(); rtb.delete();
    endtask

    // Pushes one byte; returns the cycle number of the accepting edge.
    task automatic applyStimulus(input logic [7:0] data, input logic last, output int push_cyc);
        int budget;
        budget = 0;
        push_cyc = -1;
        @(negedge i_clk);
        i_tdata = data;
        i_tlast = last;
        i_tvalid = 1'b1;
        while (push_cyc < 0 && budget < 500) begin
            if (tready_a) begin
                @(posedge i_clk);
                #1;
                push_cyc = cyc;
            end else begin
                @(negedge i_clk);
                budget++;
            end
        end
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
        if (push_cyc < 0) checkOutput("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitRx(input int na, input int nb, input int budget);
        int k;
        k = 0;
        while ((rxa.size() < na || rxb.size() < nb) && k < budget) begin
            @(negedge i_clk);
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pc, pc2, s, p, acc, nacc, budget, lows, exp_led;
        logic saw_full;
        logic [9:0] frame;
        logic [7:0] exp3a[4];
        logic [7:0] exp3b[3];

        // Test 1: single 0x55 frame, exact bit timing
        applyReset();
        applyStimulus(8'h55, 1'b0, pc);
        checkOutput("t1_level_push", 32'(level_a), 32'd1);
        @(negedge i_clk);
        checkOutput("t1_pre_start", 32'(tx_a), 32'd1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge i_clk);
                checkOutput($sformatf("t1_bit%0d_%0d", j, k), 32'(tx_a), 32'(frame[j]));
                if (j == 0 && k == 0) checkOutput("t1_level_pop", 32'(level_a), 32'd0);
            end
        end
        @(negedge i_clk);
        checkOutput("t1_idle", 32'(tx_a), 32'd1);
        checkOutput("t1_count", 32'(rxa.size()), 32'd1);
        if (rxa.size() > 0) begin
            checkOutput("t1_byte", 32'(rxa[0]), 32'h55);
            checkOutput("t1_start_cyc", 32'(rta[0]), 32'(pc + 1));
        end

        // Test 2: tvalid held across 8 bytes with a depth-4 FIFO
        applyReset();
        @(negedge i_clk);
        nacc = 0; budget = 0; saw_full = 1'b0;
        i_tdata = 8'h00; i_tlast = 1'b0; i_tvalid = 1'b1;
        while (nacc < 8 && budget < 1000) begin
            if (level_a == 3'd4 && tready_a == 1'b0) saw_full = 1'b1;
            acc = int'(tready_a);
            @(posedge i_clk);
            #1;
            if (acc != 0) begin
                nacc++;
                i_tdata = 8'(nacc);
                if (nacc == 8) i_tvalid = 1'b0;
            end
            if (nacc < 8) @(negedge i_clk);
            budget++;
        end
        i_tvalid = 1'b0;
        checkOutput("t2_accepted", 32'(nacc), 32'd8);
        checkOutput("t2_full_seen", 32'(saw_full), 32'd1);
        waitRx(8, 8, 800);
        checkOutput("t2_count_a", 32'(rxa.size()), 32'd8);
        checkOutput("t2_count_b", 32'(rxb.size()), 32'd8);
        for (int k = 0; k < 8 && k < rxa.size(); k++) begin
            checkOutput($sformatf("t2_byte%0d", k), 32'(rxa[k]), 32'(k));
            if (k > 0) checkOutput($sformatf("t2_gap%0d", k), 32'(rta[k] - rta[k-1]), 32'd41);
        end

        // Test 3: tlast triggers CR+LF on A and LF on B
        applyReset();
        applyStimulus(8'h41, 1'b1, pc);
        applyStimulus(8'h42, 1'b0, pc2);
        waitRx(4, 3, 400);
        exp3a = '{8'h41, 8'h0D, 8'h0A, 8'h42};
        exp3b = '{8'h41, 8'h0A, 8'h42};
        checkOutput("t3_count_a", 32'(rxa.size()), 32'd4);
        checkOutput("t3_count_b", 32'(rxb.size()), 32'd3);
        for (int k = 0; k < 4 && k < rxa.size(); k++) begin
            checkOutput($sformatf("t3_a%0d", k), 32'(rxa[k]), 32'(exp3a[k]));
            if (k > 0) checkOutput($sformatf("t3_gap%0d", k), 32'(rta[k] - rta[k-1]), 32'd41);
        end
        for (int k = 0; k < 3 && k < rxb.size(); k++) begin
            checkOutput($sformatf("t3_b%0d", k), 32'(rxb[k]), 32'(exp3b[k]));
        end

        // Test 4: reset during data bit 3 with three bytes queued
        applyReset();
        applyStimulus(8'h11, 1'b0, pc);
        applyStimulus(8'h22, 1'b0, pc2);
        applyStimulus(8'h33, 1'b0, pc2);
        applyStimulus(8'h44, 1'b0, pc2);
        checkOutput("t4_level_queued", 32'(level_a), 32'd3);
        s = pc + 1;
        budget = 0;
        while (cyc < s + 16 && budget < 100) begin
            @(negedge i_clk);
            budget++;
        end
        checkOutput("t4_in_bit3", 32'(tx_a), 32'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        checkOutput("t4_rst_tx", 32'(tx_a), 32'd1);
        checkOutput("t4_rst_level", 32'(level_a), 32'd0);
        checkOutput("t4_rst_tready", 32'(tready_a), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("t4_tready_after", 32'(tready_a), 32'd1);
        lows = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (tx_a !== 1'b1) lows++;
        end
        checkOutput("t4_line_quiet", 32'(lows), 32'd0);
        checkOutput("t4_no_frames", 32'(rxa.size()), 32'd0);
        checkOutput("t4_level_empty", 32'(level_a), 32'd0);

        // Test 5: LED stretch of 10 cycles per START entry
        applyReset();
        applyStimulus(8'h5A, 1'b0, pc);
        checkOutput("t5_led_pre", 32'(led_a), 32'd0);
        applyStimulus(8'hA5, 1'b0, pc2);
        s = pc + 1;
        for (int k = 0; k < 56; k++) begin
            @(negedge i_clk);
            p = cyc - s;
            exp_led = ((p >= 0 && p < 10) || (p >= 41 && p < 51)) ? 1 : 0;
            checkOutput($sformatf("t5_led_p%0d", p), 32'(led_a), 32'(exp_led));
        end

        // Test 6: full FIFO pops, then the waiting byte is accepted
        applyReset();
        applyStimulus(8'h61, 1'b0, pc);
        applyStimulus(8'h62, 1'b0, pc2);
        applyStimulus(8'h63, 1'b0, pc2);
        applyStimulus(8'h64, 1'b0, pc2);
        applyStimulus(8'h65, 1'b0, pc2);
        checkOutput("t6_full_level", 32'(level_a), 32'd4);
        @(negedge i_clk);
        i_tdata = 8'h66; i_tlast = 1'b0; i_tvalid = 1'b1;
        budget = 0;
        while (cyc < pc + 41 && budget < 100) begin
            @(negedge i_clk);
            budget++;
        end
        checkOutput("t6_pre_level", 32'(level_a), 32'd4);
        checkOutput("t6_pre_tready", 32'(tready_a), 32'd0);
        @(negedge i_clk);
        checkOutput("t6_pop_level", 32'(level_a), 32'd3);
        checkOutput("t6_pop_tready", 32'(tready_a), 32'd1);
        @(negedge i_clk);
        checkOutput("t6_push_level", 32'(level_a), 32'd4);
        checkOutput("t6_push_tready", 32'(tready_a), 32'd0);
        i_tvalid = 1'b0;
        waitRx(6, 6, 400);
        checkOutput("t6_count", 32'(rxa.size()), 32'd6);
        for (int k = 0; k < 6 && k < rxa.size(); k++) begin
            checkOutput($sformatf("t6_byte%0d", k), 32'(rxa[k]), 32'(8'h61 + k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
